// File: rtl/conv_window_sched.sv
// Convolution window scheduler.
// Walks every valid output pixel of a square source image and, for each one,
// emits its KERNEL x KERNEL tap coordinates as packed {row, col} addresses
// with a valid/ready handshake. It also provides per-window first/last tap
// markers and forwards the latched image size selector to the converter.
module conv_window_sched #(
    parameter int KERNEL = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [1:0]  SIZE_IMAGE_SRC,
    input  logic        INDEX_READY,
    output logic [31:0] INDEX_ADDRESS,
    output logic        INDEX_VALID,
    output logic [1:0]  SIZE_IMAGE_OUT,
    output logic        TAP_FIRST,
    output logic        TAP_LAST,
    output logic [31:0] OUT_INDEX,
    output logic        BUSY,
    output logic        DONE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Coordinates never exceed 63, so 7 bits cannot wrap.
    localparam logic [6:0] K_SIZE = 7'(KERNEL);
    localparam logic [6:0] K_LAST = 7'(KERNEL - 1);

    // Zero-extend a 7-bit {row, col} pair into the 32-bit packed coordinate.
    function automatic logic [31:0] pack_coord(input logic [6:0] row, input logic [6:0] col);
        return {9'd0, row, 9'd0, col};
    endfunction

    state_t      state_r, state_s;
    logic [1:0]  size_r, size_s;
    logic [6:0]  orow_r, orow_s;
    logic [6:0]  ocol_r, ocol_s;
    logic [6:0]  ky_r, ky_s;
    logic [6:0]  kx_r, kx_s;
    logic [31:0] addr_r, addr_s;
    logic [31:0] oidx_r, oidx_s;
    logic        valid_r, valid_s;
    logic        first_r, first_s;
    logic        last_r, last_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;

    logic [6:0]  m_last_s;
    logic        handshake_s;
    logic        final_tap_s;
    logic [6:0]  orow_inc_s, ocol_inc_s, ky_inc_s, kx_inc_s;

    // Last output row/col index for the latched image size: M-1 = N-KERNEL.
    always_comb begin
        m_last_s    = (7'd8 << size_r) - K_SIZE;
        handshake_s = valid_r & INDEX_READY;
        final_tap_s = (orow_r == m_last_s) && (ocol_r == m_last_s) &&
                      (ky_r == K_LAST) && (kx_r == K_LAST);
    end

    // Ripple-carry increment of the tap walker: kx, then ky, then out_c, then out_r.
    always_comb begin
        orow_inc_s = orow_r;
        ocol_inc_s = ocol_r;
        ky_inc_s   = ky_r;
        kx_inc_s   = kx_r;
        if (kx_r == K_LAST) begin
            kx_inc_s = 7'd0;
            if (ky_r == K_LAST) begin
                ky_inc_s = 7'd0;
                if (ocol_r == m_last_s) begin
                    ocol_inc_s = 7'd0;
                    orow_inc_s = orow_r + 7'd1;
                end else begin
                    ocol_inc_s = ocol_r + 7'd1;
                end
            end else begin
                ky_inc_s = ky_r + 7'd1;
            end
        end else begin
            kx_inc_s = kx_r + 7'd1;
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_s = state_r;
        size_s  = size_r;
        orow_s  = orow_r;
        ocol_s  = ocol_r;
        ky_s    = ky_r;
        kx_s    = kx_r;
        addr_s  = addr_r;
        oidx_s  = oidx_r;
        valid_s = 1'b0;
        first_s = 1'b0;
        last_s  = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (START) begin
                    state_s = ST_RUN;
                    size_s  = SIZE_IMAGE_SRC;
                    orow_s  = 7'd0;
                    ocol_s  = 7'd0;
                    ky_s    = 7'd0;
                    kx_s    = 7'd0;
                    addr_s  = 32'd0;
                    oidx_s  = 32'd0;
                    valid_s = 1'b1;
                    first_s = 1'b1;
                    last_s  = (K_LAST == 7'd0);
                    busy_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (handshake_s && final_tap_s) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                end else if (handshake_s) begin
                    orow_s  = orow_inc_s;
                    ocol_s  = ocol_inc_s;
                    ky_s    = ky_inc_s;
                    kx_s    = kx_inc_s;
                    addr_s  = pack_coord(orow_inc_s + ky_inc_s, ocol_inc_s + kx_inc_s);
                    oidx_s  = pack_coord(orow_inc_s, ocol_inc_s);
                    valid_s = 1'b1;
                    first_s = (ky_inc_s == 7'd0) && (kx_inc_s == 7'd0);
                    last_s  = (ky_inc_s == K_LAST) && (kx_inc_s == K_LAST);
                    busy_s  = 1'b1;
                end else begin
                    valid_s = 1'b1;
                    first_s = first_r;
                    last_s  = last_r;
                    busy_s  = 1'b1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, walker counters and registered outputs; reset abandons any run.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r <= ST_IDLE;
            size_r  <= 2'd0;
            orow_r  <= 7'd0;
            ocol_r  <= 7'd0;
            ky_r    <= 7'd0;
            kx_r    <= 7'd0;
            addr_r  <= 32'd0;
            oidx_r  <= 32'd0;
            valid_r <= 1'b0;
            first_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            size_r  <= size_s;
            orow_r  <= orow_s;
            ocol_r  <= ocol_s;
            ky_r    <= ky_s;
            kx_r    <= kx_s;
            addr_r  <= addr_s;
            oidx_r  <= oidx_s;
            valid_r <= valid_s;
            first_r <= first_s;
            last_r  <= last_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign INDEX_ADDRESS  = addr_r;
    assign INDEX_VALID    = valid_r;
    assign SIZE_IMAGE_OUT = size_r;
    assign TAP_FIRST      = first_r;
    assign TAP_LAST       = last_r;
    assign OUT_INDEX      = oidx_r;
    assign BUSY           = busy_r;
    assign DONE           = done_r;

endmodule

// File: tb/tb_conv_window_sched.sv
// Self-checking bench for conv_window_sched (KERNEL=3).
// Expected taps are pushed to a scoreboard queue at run start and popped on
// each handshake; outputs are sampled on the falling clock edge.
module tb_conv_window_sched;

    localparam int K = 3;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  size_src;
    logic        ready;
    logic [31:0] addr;
    logic        valid;
    logic [1:0]  size_out;
    logic        first;
    logic        last;
    logic [31:0] oidx;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    conv_window_sched #(.KERNEL(K)) dut (
        .CLK            (clk),
        .RESET          (rst),
        .START          (start),
        .SIZE_IMAGE_SRC (size_src),
        .INDEX_READY    (ready),
        .INDEX_ADDRESS  (addr),
        .INDEX_VALID    (valid),
        .SIZE_IMAGE_OUT (size_out),
        .TAP_FIRST      (first),
        .TAP_LAST       (last),
        .OUT_INDEX      (oidx),
        .BUSY           (busy),
        .DONE           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [70:0] obs, input logic [70:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {valid, busy, done, size_out, first, last, addr, oidx}
    function automatic logic [70:0] obs_vec();
        return {valid, busy, done, size_out, first, last, addr, oidx};
    endfunction

    // Starts a run at the current falling edge (DUT idle) and checks it to completion.
    // stall_at/start_at/abort_at are accepted-tap indices, -1 to disable.
    task automatic do_run(input logic [1:0] sz, input int stall_at, input int start_at, input int abort_at);
        logic [65:0] q[$];
        logic [65:0] e;
        logic [65:0] last_e;
        int m, total, accepted, cycles, stalled, busy_cycles;
        bit pulsed;
        m = (8 << sz) - K + 1;
        for (int r = 0; r < m; r++)
            for (int c = 0; c < m; c++)
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++)
                        q.push_back({(ky == 0 && kx == 0), (ky == K-1 && kx == K-1),
                                     16'(r + ky), 16'(c + kx), 16'(r), 16'(c)});
        total = q.size();
        accepted = 0; cycles = 0; stalled = 0; busy_cycles = 0; pulsed = 1'b0;
        last_e = '0;
        start = 1'b1;
        size_src = sz;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (accepted < total && cycles < 2 * total + 20) begin
            e = q[0];
            if (accepted == abort_at) begin
                rst = 1'b0;
                #1;
                chk("abort_async", {valid, busy, done}, 3'b000);
                @(negedge clk);
                chk("abort_no_done", {valid, busy, done}, 3'b000);
                rst = 1'b1;
                return;
            end
            chk("tap", obs_vec(), {3'b110, sz, e});
            if (busy === 1'b1) busy_cycles++;
            if (sz == 2'd0 && accepted == 0)
                chk("first_tap", {first, addr}, {1'b1, 32'h0000_0000});
            if (sz == 2'd0 && accepted == 8)
                chk("tap9", {last, addr, oidx}, {1'b1, 32'h0002_0002, 32'h0000_0000});
            if (sz == 2'd0 && accepted == 9)
                chk("tap10", {addr, oidx}, {32'h0000_0001, 32'h0000_0001});
            if (sz == 2'd0 && accepted == total - 1)
                chk("last_tap_n8", {last, addr, oidx}, {1'b1, 32'h0007_0007, 32'h0005_0005});
            if (sz == 2'd3 && accepted == total - 1)
                chk("last_tap_n64", {last, addr, oidx}, {1'b1, 32'h003F_003F, 32'h003D_003D});
            if (accepted == start_at && !pulsed) begin
                start = 1'b1;
                size_src = 2'b11;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (accepted == stall_at && stalled < 3) begin
                ready = 1'b0;
                stalled++;
            end else begin
                ready = 1'b1;
            end
            if (ready) begin
                last_e = q.pop_front();
                accepted++;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        chk("tap_count", 71'(accepted), 71'(total));
        chk("busy_cycles", 71'(busy_cycles), 71'(total + stalled));
        chk("done_pulse", obs_vec(), {3'b001, sz, 2'b00, last_e[63:0]});
        @(negedge clk);
        chk("done_clear", obs_vec(), {3'b000, sz, 2'b00, last_e[63:0]});
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        size_src = 2'b00;
        ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("in_reset", obs_vec(), 71'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("after_reset", obs_vec(), 71'd0);

        do_run(2'd0, -1, -1, -1);    // full run, N=8
        do_run(2'd1,  5, -1, -1);    // backpressure on tap 5, N=16
        do_run(2'd0, -1, 50, -1);    // mid-run START and size change ignored
        do_run(2'd0, -1, -1, 100);   // reset at tap 100
        do_run(2'd0, -1, -1, -1);    // restart from (0,0) after abort
        do_run(2'd3, -1, -1, -1);    // N=64 boundary
        do_run(2'd0, -1, -1, -1);    // back-to-back start after N=64

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_window_sched.md
# conv_window_sched

Convolution window scheduler for the pipelined CPU's image-convolution path. On a start request it walks every valid (unpadded) output pixel of a square source image and, for each, emits the KERNEL×KERNEL tap coordinates as packed index addresses. These addresses feed the index-to-memory address converter directly, with a valid/ready handshake to the load stage and per-tap first/last markers for the accumulator. The image size selector is latched for the whole run and forwarded to the converter.

## Interface

- KERNEL, 3, kernel side length in taps; legal values 1..7.
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- START  in  1  run request; sampled only in IDLE.
- SIZE_IMAGE_SRC  in  2  image side N: 00→8, 01→16, 10→32, 11→64; latched on accepted START.
- INDEX_READY  in  1  downstream accepts the current tap.
- INDEX_ADDRESS  out  32  tap coordinate {row[31:16], col[15:0]}, to the converter.
- INDEX_VALID  out  1  INDEX_ADDRESS holds a valid tap.
- SIZE_IMAGE_OUT  out  2  latched size selector, to the converter's SIZE_IMAGE_SRC.
- TAP_FIRST  out  1  current tap is ky=0, kx=0 of its window.
- TAP_LAST  out  1  current tap is ky=KERNEL-1, kx=KERNEL-1 of its window.
- OUT_INDEX  out  32  output pixel {out_row[31:16], out_col[15:0]} owning the current tap.
- BUSY  out  1  high in RUN.
- DONE  out  1  one-cycle pulse after the final tap is accepted.

## Operation

- States: IDLE, RUN, DONE.
- IDLE → RUN on START=1. Latch the size selector. Clear out_r, out_c, ky and kx to 0.
- In RUN: INDEX_VALID=1 and INDEX_ADDRESS={out_r+ky, out_c+kx}, zero-extended to 16 bits per half. OUT_INDEX={out_r, out_c}.
- Advance only on handshake (INDEX_VALID & INDEX_READY). The increment order is kx, then ky, then out_c, then out_r:
  - kx wraps at KERNEL-1 and carries into ky.
  - ky wraps at KERNEL-1 and carries into out_c.
  - out_c wraps at M-1 and carries into out_r, where M = N-KERNEL+1.
- RUN → DONE on handshake of the tap with out_r=M-1, out_c=M-1, ky=kx=KERNEL-1.
- DONE → IDLE unconditionally after one cycle.
- Coordinate arithmetic uses 7-bit unsigned values. A tap row or column never exceeds N-1 (max 63), so no wrap-around can occur.
- Taps per run = KERNEL²·M². For KERNEL=3: N=8→324, N=16→1764, N=32→8100, N=64→34596.
- START in RUN or DONE is ignored; it does not queue.
- SIZE_IMAGE_SRC changes during RUN are ignored. SIZE_IMAGE_OUT holds the latched value until the next accepted START.
- INDEX_READY low holds every output stable. No counter moves while stalled.
- RESET asserted at any time, including mid-run: return immediately to IDLE and abandon the run. No DONE pulse is produced.

## Timing

- All outputs are registered.
- Reset values:
  - INDEX_ADDRESS=0, OUT_INDEX=0, SIZE_IMAGE_OUT=00.
  - INDEX_VALID=0, TAP_FIRST=0, TAP_LAST=0, BUSY=0, DONE=0.
- START=1 in IDLE at edge t: first tap (0,0) is valid with TAP_FIRST=1 and BUSY=1 from t+1.
- Handshake at edge t: the next tap is presented at t+1, giving one tap per cycle when READY is held high.
- A run with READY always high and KERNEL=3, N=8 keeps BUSY high for exactly 324 cycles.
- Final handshake at edge t: at t+1 INDEX_VALID=0, BUSY=0, DONE=1. At t+2 the block is in IDLE and DONE=0. The earliest restart is START at t+2, with its first tap at t+3.
- Outside RUN: INDEX_VALID, TAP_FIRST and TAP_LAST are 0. INDEX_ADDRESS and OUT_INDEX hold their last values.
- The converter's one-cycle registered latency is absorbed downstream. This block does not delay TAP_FIRST or TAP_LAST to match it.

## Test plan

- **Reset:** hold RESET=0 for 2 cycles, then release → all outputs at their reset values; block in IDLE.
- **Full run, N=8:** SIZE_IMAGE_SRC=00, START pulse, READY=1 → 324 taps.
  - First tap INDEX_ADDRESS=0x00000000 with TAP_FIRST=1.
  - Ninth tap 0x00020002 with TAP_LAST=1 and OUT_INDEX=0x00000000.
  - Tenth tap 0x00000001 with OUT_INDEX=0x00000001.
  - Last tap 0x00070007 with OUT_INDEX=0x00050005.
  - DONE pulse one cycle after the last tap.
- **Backpressure, N=16:** drive READY low for 3 cycles on tap 5 → INDEX_ADDRESS, OUT_INDEX and the TAP flags stay stable across the stall. The total accepted tap count is still 1764, and the address sequence matches the unstalled run.
- **Ignored inputs:** mid-run, pulse START and change SIZE_IMAGE_SRC to 11 → no restart; SIZE_IMAGE_OUT stays 00; tap count is still 324.
- **Reset mid-run:** assert RESET at tap 100 → INDEX_VALID=0 and BUSY=0 asynchronously; no DONE. A new START then begins from tap (0,0).
- **N=64 boundary:** SIZE_IMAGE_SRC=11 → last tap is 0x003F003F with OUT_INDEX=0x003D003D; 34596 taps total; DONE then IDLE, and a back-to-back START two cycles after the final handshake is accepted.
